// File: rtl/mmbus_arbiter.sv
// -----------------------------------------------------------------------------
// mmbus_arbiter
//
// Round-robin arbiter that shares the single memory-mapped port-b bus
// (socram, uartmm, ledwriter, ...) between NREQ requesters such as the CPU
// data port, DMA, VGA fetch and HLS cores.
//
// One transaction is in flight at a time. A write is presented for one cycle
// and then acknowledged. A read is presented for one cycle, after which the
// arbiter waits for the peripheral strobe and returns the captured data along
// with a one-cycle ack to the winning requester.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   IDLE_ADDR  address driven while no transaction is issued (decodes to nothing)
//   TIMEOUT    read-wait limit in cycles (only used with ARB_TIMEOUT_EN)
//
// Optional feature macro
//   ARB_TIMEOUT_EN  when defined, a read that sees no strobe for TIMEOUT cycles
//                   completes with rdata=32'hDEAD_BEEF and err=1. When
//                   undefined, the read wait is unbounded and err is always 0.
//
// Ports
//   clk         clock
//   rst         synchronous, active-low reset
//   req         per-requester request, held high until ack
//   req_addr    flattened request addresses, slot i = [32*i+31:32*i]
//   req_wdata   flattened write data, same slot layout
//   req_we      per-requester write enable (1 = write, 0 = read)
//   ack         one-cycle completion pulse to the granted requester
//   rdata       read data, valid while ack is high (0 for writes)
//   err         read timeout indication, pulses with ack
//   bus_addr    peripheral address (addr_b)
//   bus_wdata   peripheral write data (data_b_in)
//   bus_we      peripheral write enable (data_b_we)
//   bus_rdata   OR/mux of peripheral read data (data_b)
//   bus_strobe  OR of peripheral read strobes (strobe_b)
// -----------------------------------------------------------------------------
module mmbus_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
    parameter int          TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    input  logic [NREQ-1:0]      req_we,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic                 err,
    output logic [31:0]          bus_addr,
    output logic [31:0]          bus_wdata,
    output logic                 bus_we,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_strobe
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("mmbus_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     gnt_q;
    logic              we_q;
    logic [NREQ-1:0]   ack_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic              bus_we_q;

`ifdef ARB_TIMEOUT_EN
    // At least 5 bits, wide enough to hold TIMEOUT-1.
    localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    logic [CW-1:0]     cnt_q;
`endif

    // Unpack the flattened request buses into per-slot words.
    logic [31:0] slot_addr  [NREQ];
    logic [31:0] slot_wdata [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign slot_addr[i]  = req_addr[32*i +: 32];
        assign slot_wdata[i] = req_wdata[32*i +: 32];
    end

    // Round-robin pick: first set request bit starting at ptr_q, wrapping mod NREQ.
    logic [IW-1:0] sel_d;
    logic [IW-1:0] scan_d;
    logic          found_d;

    always_comb begin
        sel_d   = ptr_q;
        scan_d  = '0;
        found_d = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            scan_d = IW'((int'(ptr_q) + k) % NREQ);
            if (!found_d && req[scan_d]) begin
                found_d = 1'b1;
                sel_d   = scan_d;
            end
        end
    end

    // Single registered FSM; every output is a flop updated on the transition
    // into the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            we_q        <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            bus_addr_q  <= IDLE_ADDR;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus_addr_q <= IDLE_ADDR;
                    bus_we_q   <= 1'b0;
                    if (found_d) begin
                        // Latch the winner straight onto the bus for the ISSUE cycle.
                        gnt_q       <= sel_d;
                        we_q        <= req_we[sel_d];
                        bus_addr_q  <= slot_addr[sel_d];
                        bus_wdata_q <= slot_wdata[sel_d];
                        bus_we_q    <= req_we[sel_d];
                        state_q     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Address is on the bus for exactly this one cycle.
                    bus_addr_q <= IDLE_ADDR;
                    bus_we_q   <= 1'b0;
                    if (we_q) begin
                        ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus_strobe) begin
                        ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
                        rdata_q <= bus_rdata;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
                        rdata_q <= 32'hDEAD_BEEF;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    // req is not sampled here: the requester drops it on this edge.
                    ack_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;

endmodule

// File: tb/tb_mmbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mmbus_arbiter
//
// Directed bench for mmbus_arbiter with a small socram-like peripheral model
// (registered read data and strobe one cycle after the address is presented,
// decoding addresses below 32'h100). Expected completions are queued when a
// request is raised and checked against each ack as it appears.
// -----------------------------------------------------------------------------
module tb_mmbus_arbiter;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [32*NREQ-1:0]  req_addr = '0;
    logic [32*NREQ-1:0]  req_wdata = '0;
    logic [NREQ-1:0]     req_we = '0;
    logic [NREQ-1:0]     ack;
    logic [31:0]         rdata;
    logic                err;
    logic [31:0]         bus_addr;
    logic [31:0]         bus_wdata;
    logic                bus_we;
    logic [31:0]         bus_rdata = '0;
    logic                bus_strobe = 1'b0;

    mmbus_arbiter #(
        .NREQ      (NREQ),
        .IDLE_ADDR (32'hFFFF_FFFF),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_we     (req_we),
        .ack        (ack),
        .rdata      (rdata),
        .err        (err),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_we     (bus_we),
        .bus_rdata  (bus_rdata),
        .bus_strobe (bus_strobe)
    );

    always #5 clk = ~clk;

    // socram-like peripheral: writes land on the edge, reads answer next cycle.
    logic [31:0] mem [256];

    always @(posedge clk) begin
        bus_strobe <= 1'b0;
        if (bus_addr < 32'h100) begin
            if (bus_we) begin
                mem[bus_addr[7:0]] <= bus_wdata;
            end else begin
                bus_rdata  <= mem[bus_addr[7:0]];
                bus_strobe <= 1'b1;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
        int          at;      // expected ack cycle, -1 = any
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    int          we_pulses = 0;
    int          rd_issues = 0;
    logic [31:0] we_addr  = '0;
    logic [31:0] we_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input int idx, input logic [31:0] rd, input logic e, input int at);
        exp_t x;
        x.idx   = idx;
        x.rdata = rd;
        x.err   = e;
        x.at    = at;
        sb.push_back(x);
    endtask

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d, input logic we);
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
        req_we[i]             = we;
        req[i]                = 1'b1;
    endtask

    // One clock; observe on the falling edge, then retire any ack.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cyc_cnt++;
        if (bus_we) begin
            we_pulses++;
            we_addr = bus_addr;
            we_data = bus_wdata;
        end
        if (bus_addr == 32'd5 && !bus_we) rd_issues++;
        if (ack !== '0) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_vec", 32'(ack), 32'd1 << e.idx);
                chk("rdata", rdata, e.rdata);
                chk("err", 32'(err), 32'(e.err));
                if (e.at >= 0) chk("latency", 32'(cyc_cnt), 32'(e.at));
            end
            req = req & ~ack;
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() > 0 && k < budget) begin
            cyc();
            k++;
        end
        if (sb.size() > 0) begin
            chk("ack_timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (3) cyc();
        rst = 1'b1;
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) cyc();
        chk("rst_bus_addr", bus_addr, 32'hFFFF_FFFF);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_bus_addr", bus_addr, 32'hFFFF_FFFF);
        end

        // Write from requester 0: single bus_we cycle, ack at N+2
        we_pulses = 0;
        n = cyc_cnt;
        issue(0, 32'd5, 32'h1234, 1'b1);
        push(0, 32'd0, 1'b0, n + 2);
        drain(20);
        repeat (2) cyc();
        chk("write_pulses", 32'(we_pulses), 32'd1);
        chk("write_addr", we_addr, 32'd5);
        chk("write_data", we_data, 32'h1234);

        // Read from requester 2: ack at N+3, address shown once
        rd_issues = 0;
        n = cyc_cnt;
        issue(2, 32'd5, 32'd0, 1'b0);
        push(2, 32'h1234, 1'b0, n + 3);
        drain(20);
        repeat (2) cyc();
        chk("read_issue_once", 32'(rd_issues), 32'd1);

        // Back to pointer 0, then all four held: order 0,1,2,3
        do_reset();
        cyc();
        issue(0, 32'd16, 32'h0000_00A0, 1'b1);
        issue(1, 32'd5,  32'd0,         1'b0);
        issue(2, 32'd17, 32'h0000_00A2, 1'b1);
        issue(3, 32'd5,  32'd0,         1'b0);
        push(0, 32'd0,    1'b0, -1);
        push(1, 32'h1234, 1'b0, -1);
        push(2, 32'd0,    1'b0, -1);
        push(3, 32'h1234, 1'b0, -1);
        drain(60);
        cyc();

        // Pointer is back at 0: req=1001 grants 0 then 3
        issue(0, 32'd17, 32'd0, 1'b0);
        issue(3, 32'd16, 32'd0, 1'b0);
        push(0, 32'h0000_00A2, 1'b0, -1);
        push(3, 32'h0000_00A0, 1'b0, -1);
        drain(40);
        cyc();
        chk("req_all_dropped", 32'(req), 32'd0);

        // Reset while stuck in WAIT on an unmapped address: no ack
        issue(1, 32'h0002_0000, 32'd0, 1'b0);
        repeat (5) cyc();
        rst = 1'b0;
        req = '0;
        cyc();
        chk("wait_rst_bus_addr", bus_addr, 32'hFFFF_FFFF);
        chk("wait_rst_ack", 32'(ack), 32'd0);
        rst = 1'b1;
        repeat (3) cyc();
        chk("wait_rst_no_ack", 32'(ack), 32'd0);
        n = cyc_cnt;
        issue(1, 32'd5, 32'd0, 1'b0);
        push(1, 32'h1234, 1'b0, n + 3);
        drain(20);
        cyc();

`ifdef ARB_TIMEOUT_EN
        // Unmapped read times out after 16 WAIT cycles
        n = cyc_cnt;
        issue(3, 32'h0002_0000, 32'd0, 1'b0);
        push(3, 32'hDEAD_BEEF, 1'b1, n + 18);
        drain(40);
        cyc();
        chk("timeout_err_cleared", 32'(err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
